// File: rtl/conv_layer.sv
// Single-channel 2D valid convolution (IN_H x IN_W map, K x K kernel, bias, optional ReLU).
// One multiply-accumulate per clock; results land in a registered output map, then done rises.
module conv_layer #(
    parameter int unsigned IN_W = 8,
    parameter int unsigned IN_H = 8,
    parameter int unsigned K    = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned RELU = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [DW*IN_W*IN_H-1:0]                input_fm,
    input  logic [DW*K*K-1:0]                      kernel,
    input  logic [DW-1:0]                          bias,
    output logic                                   busy,
    output logic                                   done,
    output logic [DW*(IN_W-K+1)*(IN_H-K+1)-1:0]    output_fm
);

    localparam int unsigned OUT_W     = IN_W - K + 1;
    localparam int unsigned OUT_H     = IN_H - K + 1;
    localparam int unsigned TAPS      = K * K;
    localparam int unsigned NPIX      = IN_W * IN_H;
    localparam int unsigned NOUT      = OUT_W * OUT_H;
    localparam int unsigned PW        = 2 * DW;
    localparam int unsigned AW        = 2 * DW + 4;
    localparam int unsigned PIX_BITS  = (NPIX  > 1) ? $clog2(NPIX)  : 1;
    localparam int unsigned OUT_BITS  = (NOUT  > 1) ? $clog2(NOUT)  : 1;
    localparam int unsigned TAP_BITS  = (TAPS  > 1) ? $clog2(TAPS)  : 1;
    localparam int unsigned KB        = (K     > 1) ? $clog2(K)     : 1;
    localparam int unsigned ROW_BITS  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int unsigned COL_BITS  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic signed [AW-1:0] SAT_MAX = AW'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic        [ROW_BITS-1:0] row;
    logic        [COL_BITS-1:0] col;
    logic        [TAP_BITS-1:0] tap;
    logic        [KB-1:0]       kr;
    logic        [KB-1:0]       kc;
    logic signed [AW-1:0]       acc;

    logic signed [DW-1:0] pix_arr [NPIX];
    logic signed [DW-1:0] wt_arr  [TAPS];
    logic signed [DW-1:0] out_arr [NOUT];

    logic        [PIX_BITS-1:0] pix_idx;
    logic        [OUT_BITS-1:0] out_idx;
    logic signed [DW-1:0]       pixel;
    logic signed [DW-1:0]       weight;
    logic signed [PW-1:0]       prod;
    logic signed [DW-1:0]       res;
    logic                       last_tap;
    logic                       last_col;
    logic                       last_row;

    // Unflatten inputs and flatten the result map.
    for (genvar p = 0; p < NPIX; p++) begin : g_pix
        assign pix_arr[p] = input_fm[p*DW +: DW];
    end
    for (genvar t = 0; t < TAPS; t++) begin : g_wt
        assign wt_arr[t] = kernel[t*DW +: DW];
    end
    for (genvar q = 0; q < NOUT; q++) begin : g_out
        assign output_fm[q*DW +: DW] = out_arr[q];
    end

    // Tap fetch, full-precision product, saturation and ReLU.
    always_comb begin
        pix_idx  = PIX_BITS'((32'(row) + 32'(kr)) * IN_W + 32'(col) + 32'(kc));
        out_idx  = OUT_BITS'(32'(row) * OUT_W + 32'(col));
        pixel    = pix_arr[pix_idx];
        weight   = wt_arr[tap];
        prod     = PW'(pixel) * PW'(weight);
        last_tap = (tap == TAP_BITS'(TAPS - 1));
        last_col = (col == COL_BITS'(OUT_W - 1));
        last_row = (row == ROW_BITS'(OUT_H - 1));
        if (acc > SAT_MAX) begin
            res = SAT_MAX[DW-1:0];
        end else if (acc < SAT_MIN) begin
            res = SAT_MIN[DW-1:0];
        end else begin
            res = acc[DW-1:0];
        end
        if ((RELU != 0) && res[DW-1]) begin
            res = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = MAC;
            MAC:     if (last_tap) state_next = WRITE;
            WRITE:   state_next = (last_col && last_row) ? DONE : CLEAR;
            DONE:    if (start) state_next = CLEAR;
            default: state_next = IDLE;
        endcase
    end

    // Counters, accumulator, status flags and the output map.
    always_ff @(posedge clk) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            tap  <= '0;
            kr   <= '0;
            kc   <= '0;
            acc  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            for (int q = 0; q < NOUT; q++) begin
                out_arr[q] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        row  <= '0;
                        col  <= '0;
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end
                CLEAR: begin
                    acc <= AW'($signed(bias));
                    tap <= '0;
                    kr  <= '0;
                    kc  <= '0;
                end
                MAC: begin
                    acc <= acc + AW'(prod);
                    tap <= tap + TAP_BITS'(1);
                    if (kc == KB'(K - 1)) begin
                        kc <= '0;
                        kr <= kr + KB'(1);
                    end else begin
                        kc <= kc + KB'(1);
                    end
                end
                WRITE: begin
                    out_arr[out_idx] <= res;
                    if (!last_col) begin
                        col <= col + COL_BITS'(1);
                    end else if (!last_row) begin
                        col <= '0;
                        row <= row + ROW_BITS'(1);
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
